dds_freq_est: RTL and testbench

- Measures the frequency of a sampled periodic signal using zero crossings and outputs the equivalent DDS tuning word.
- Performs the inverse of the DDS: samples go in, a tuning word comes out. Feeding the result to a DDS with the same PW/TW reproduces the measured frequency.
- Used for loopback calibration of the DDS and for tracking external tones.

---
 rtl/dds_freq_est.sv | 182 ++++++++++++++++++
 tb/tb_dds_freq_est.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_freq_est.sv
// Zero-crossing frequency estimator: averages 2**NCYC_LOG2 signal periods and
// converts the sample count into the DDS tuning word that reproduces the tone.
module dds_freq_est #(
  parameter int unsigned IW        = 24,
  parameter int unsigned PW        = 15,
  parameter int unsigned TW        = 10,
  parameter int unsigned CW        = 16,
  parameter int unsigned NCYC_LOG2 = 2,
  parameter int          HYST      = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [IW-1:0] sample,
  output logic [TW-1:0] tuning_word,
  output logic          tw_valid,
  output logic          locked,
  output logic          timeout,
  output logic          overrun
);
  localparam int unsigned          QW       = PW + NCYC_LOG2 + 1;
  localparam int unsigned          SW       = $clog2(QW);
  localparam logic [SW-1:0]        STEP_MSB = SW'(QW - 1);
  localparam logic [NCYC_LOG2:0]   PER_LAST = (NCYC_LOG2 + 1)'(2 ** NCYC_LOG2 - 1);
  localparam logic signed [IW-1:0] NEG_HYST = IW'(-HYST);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t             state_q, state_d;
  logic               armed_q, cross_q, ce_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NCYC_LOG2:0] per_q, per_d;
  logic               snap, timeout_d;

  logic               busy_q, busy_d;
  logic [SW-1:0]      step_q, step_d;
  logic [CW-1:0]      rem_q, rem_d, den_q, den_d, rem_sub;
  logic [CW:0]        rem_sh;
  logic [QW-2:0]      quo_q, quo_d;
  logic [QW-1:0]      quo_nx;
  logic               fits, last;

  logic [TW-1:0]      tw_q, tw_d;
  logic               tw_valid_q, locked_q, locked_d, timeout_q, overrun_q, overrun_d;

  logic               pos, neg;

  assign pos = ~sample[IW-1];
  assign neg = $signed(sample) <= NEG_HYST;

  // Detector output is registered together with the qualifier so the FSM sees
  // each crossing alongside the ce that carried it, one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      cross_q <= 1'b0;
      ce_q    <= 1'b0;
    end else begin
      ce_q    <= ce;
      cross_q <= ce && armed_q && pos;
      if (ce) begin
        if (armed_q && pos) armed_q <= 1'b0;
        else if (neg)       armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    snap      = 1'b0;
    timeout_d = 1'b0;
    if (ce_q) begin
      case (state_q)
        IDLE: begin
          if (cross_q) begin
            cnt_d   = CW'(1);
            per_d   = '0;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (cnt_q == '1) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            per_d     = '0;
            state_d   = IDLE;
          end else if (cross_q && per_q == PER_LAST) begin
            snap  = 1'b1;
            cnt_d = CW'(1);
            per_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cross_q) per_d = per_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Restoring division of the single-bit dividend 2**(QW-1), MSB first.
  always_comb begin
    rem_sh  = {rem_q, busy_q && (step_q == STEP_MSB)};
    fits    = rem_sh >= {1'b0, den_q};
    rem_sub = rem_sh[CW-1:0] - den_q;
    quo_nx  = {quo_q, fits};
    last    = busy_q && (step_q == '0);

    busy_d    = busy_q;
    step_d    = step_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    den_d     = den_q;
    overrun_d = overrun_q;
    tw_d      = tw_q;
    locked_d  = locked_q;

    if (busy_q) begin
      rem_d  = fits ? rem_sub : rem_sh[CW-1:0];
      quo_d  = quo_nx[QW-2:0];
      step_d = step_q - SW'(1);
      busy_d = !last;
    end
    // A divider finishing this cycle counts as free, so back-to-back windows chain.
    if (snap) begin
      if (!busy_q || last) begin
        den_d  = cnt_q;
        busy_d = 1'b1;
        step_d = STEP_MSB;
        rem_d  = '0;
        quo_d  = '0;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (last) begin
      tw_d     = (|quo_nx[QW-1:TW]) ? '1 : quo_nx[TW-1:0];
      locked_d = 1'b1;
    end
    if (timeout_d) locked_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      per_q      <= '0;
      busy_q     <= 1'b0;
      step_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      den_q      <= '0;
      tw_q       <= '0;
      tw_valid_q <= 1'b0;
      locked_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      busy_q     <= busy_d;
      step_q     <= step_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      den_q      <= den_d;
      tw_q       <= tw_d;
      tw_valid_q <= last;
      locked_q   <= locked_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tuning_word = tw_q;
  assign tw_valid    = tw_valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_dds_freq_est.sv
// Scoreboard bench for dds_freq_est: a window-level reference model predicts each
// estimate and timeout with its clock edge; a monitor pops and compares.
module tb_dds_freq_est;
  localparam int IW = 24, PW = 15, TW = 10, CW = 16, NL = 2, HYST = 256;
  localparam int QW       = PW + NL + 1;
  localparam int TW_MAX   = (1 << TW) - 1;
  localparam int CNT_MAX  = (1 << CW) - 1;
  localparam int NPER     = 1 << NL;
  localparam int DIVIDEND = 1 << (PW + NL);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce  = 1'b0;
  logic [IW-1:0] sample = '0;
  logic [TW-1:0] tuning_word;
  logic          tw_valid, locked, timeout, overrun;

  dds_freq_est #(.IW(IW), .PW(PW), .TW(TW), .CW(CW), .NCYC_LOG2(NL), .HYST(HYST)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sample(sample), .tuning_word(tuning_word),
    .tw_valid(tw_valid), .locked(locked), .timeout(timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, edge_n = 0, ph = 0;
  always @(posedge clk) edge_n++;

  int exp_tw_val[$], exp_tw_edge[$], exp_to_edge[$];
  bit m_armed, m_meas, m_ovr, m_locked;
  int m_idx, m_start, m_per, m_div_done, m_tw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic void model_reset();
    m_armed = 0; m_meas = 0; m_ovr = 0; m_locked = 0;
    m_idx = 0; m_start = 0; m_per = 0; m_div_done = 0; m_tw = 0;
    exp_tw_val.delete(); exp_tw_edge.delete(); exp_to_edge.delete();
  endfunction

  // One ce-qualified sample, clocked in at edge e. Windows are measured as the
  // distance in sample indices between the crossings that bound them.
  function automatic void model_step(input int s, input int e);
    bit cr;
    int den, snap, q;
    cr = m_armed && (s >= 0);
    if (cr) m_armed = 0;
    else if (s <= -HYST) m_armed = 1;
    if (m_meas) begin
      if (m_idx - m_start == CNT_MAX) begin
        exp_to_edge.push_back(e + 1);
        m_meas = 0;
        m_locked = 0;
      end else if (cr) begin
        m_per++;
        if (m_per == NPER) begin
          den = m_idx - m_start;
          snap = e + 1;
          m_start = m_idx;
          m_per = 0;
          if (snap >= m_div_done) begin
            q = (den == 0) ? TW_MAX : DIVIDEND / den;
            if (q > TW_MAX) q = TW_MAX;
            exp_tw_val.push_back(q);
            exp_tw_edge.push_back(snap + QW);
            m_div_done = snap + QW;
            m_tw = q;
            m_locked = 1;
          end else begin
            m_ovr = 1;
          end
        end
      end
    end else if (cr) begin
      m_meas = 1;
      m_start = m_idx;
      m_per = 0;
    end
    m_idx++;
  endfunction

  task automatic drive(input bit c, input int s);
    @(posedge clk);
    #1;
    ce = c;
    sample = IW'(s);
    if (c) model_step(s, edge_n + 1);
  endtask

  // mode 0: ce always high, 1: ce alternates 1,0, 2: random ce gaps
  task automatic sq(input int n, input int period, input int amp, input int mode);
    for (int k = 0; k < n; k++) begin
      int s;
      s = ((ph % period) < (period / 2)) ? amp : -amp;
      ph++;
      if (mode == 2) while ($urandom_range(3) == 0) drive(1'b0, int'($urandom));
      drive(1'b1, s);
      if (mode == 1) drive(1'b0, int'($urandom));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0);
  endtask

  task automatic status(input string tag);
    chk({tag, "_tuning_word"}, 32'(tuning_word), m_tw);
    chk({tag, "_locked"}, 32'(locked), 32'(m_locked));
    chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tuning_word"}, 32'(tuning_word), 0);
    chk({tag, "_tw_valid"}, 32'(tw_valid), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tw_valid) begin
          if (exp_tw_val.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tw_valid: got value %0d at edge %0d, required none", tuning_word, edge_n);
          end else begin
            chk("tw_value", 32'(tuning_word), exp_tw_val.pop_front());
            chk("tw_edge", edge_n, exp_tw_edge.pop_front());
            chk("locked_on_tw", 32'(locked), 1);
          end
        end
        if (timeout) begin
          if (exp_to_edge.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_timeout: got pulse at edge %0d, required none", edge_n);
          end else begin
            chk("timeout_edge", edge_n, exp_to_edge.pop_front());
            chk("locked_after_timeout", 32'(locked), 0);
          end
        end
      end
    end
  end

  initial begin
    bit in_flight;
    int k;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    sq(1800, 100, 1000, 0);
    idle(30);
    status("sq100");
    chk("sq100_tw_327", 32'(tuning_word), 327);
    chk("sq100_locked", 32'(locked), 1);

    sq(1600, 100, 1000, 1);
    idle(30);
    status("ce_toggle");
    chk("ce_toggle_tw_327", 32'(tuning_word), 327);

    for (int i = 0; i < 66000; i++) drive(1'b1, 0);
    idle(30);
    status("const0");
    chk("const0_locked", 32'(locked), 0);
    chk("const0_tw_hold", 32'(tuning_word), 327);

    k = 0;
    in_flight = 0;
    while (k < 3000 && !in_flight) begin
      sq(1, 100, 1000, 0);
      in_flight = (m_div_done > edge_n + 4) && (m_div_done - QW <= edge_n);
      k++;
    end
    chk("divide_in_flight", 32'(in_flight), 1);
    #1;
    rst = 1'b1;
    ce = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sq(1800, 100, 1000, 0);
    idle(30);
    status("reconverge");
    chk("reconverge_tw_327", 32'(tuning_word), 327);

    for (int seg = 0; seg < 3; seg++) begin
      ph = 0;
      sq(1200, int'($urandom_range(150, 10)), int'($urandom_range(5000, 300)), 2);
    end
    idle(30);
    status("random");

    ph = 0;
    sq(64, 4, 1000, 0);
    idle(30);
    status("period4");
    chk("period4_tw_sat", 32'(tuning_word), TW_MAX);
    chk("period4_overrun", 32'(overrun), 1);

    chk("pending_tw", exp_tw_val.size(), 0);
    chk("pending_timeout", exp_to_edge.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
